// File: rtl/uop_queue.sv
// Multi-lane in-order micro-op queue: circular buffer accepting up to ENQ_WIDTH
// entries and presenting up to DEQ_WIDTH of the oldest entries per cycle.
module uop_queue #(
  parameter int UOP_WIDTH = 66,
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic [ENQ_WIDTH-1:0]           enq_valid,
  input  logic [ENQ_WIDTH*UOP_WIDTH-1:0] enq_uop,
  output logic                           enq_ready,
  output logic [DEQ_WIDTH-1:0]           deq_valid,
  output logic [DEQ_WIDTH*UOP_WIDTH-1:0] deq_uop,
  input  logic [DEQ_WIDTH-1:0]           deq_ready,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UOP_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;

  logic                 accept;
  logic [PTR_W-1:0]     enq_off [ENQ_WIDTH];
  logic [CNT_W-1:0]     enq_cnt;
  logic [CNT_W-1:0]     enq_add;
  logic [CNT_W-1:0]     deq_k;
  logic                 deq_run;

  // Room is judged on the registered count only; same-cycle dequeues give no credit.
  assign enq_ready = (count <= CNT_W'(DEPTH - ENQ_WIDTH));
  assign accept    = enq_ready && !flush;
  assign enq_add   = accept ? enq_cnt : '0;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Compact valid lanes: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_off[i] = PTR_W'(enq_cnt);
      enq_cnt    = enq_cnt + CNT_W'(enq_valid[i]);
    end
  end

  // In-order consumption stops at the first lane that is not both valid and ready.
  always_comb begin
    deq_k   = '0;
    deq_run = 1'b1;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (deq_run && deq_valid[i] && deq_ready[i]) begin
        deq_k = deq_k + 1'b1;
      end else begin
        deq_run = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_deq
    assign deq_valid[g]                      = (count > CNT_W'(g));
    assign deq_uop[g*UOP_WIDTH +: UOP_WIDTH] = mem[head + PTR_W'(g)];
  end

  // NOTE: payload storage has no reset; head/tail/count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_valid[i]) begin
          mem[tail + enq_off[i]] <= enq_uop[i*UOP_WIDTH +: UOP_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_k);
      tail  <= tail + PTR_W'(enq_add);
      count <= count + enq_add - deq_k;
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
// Randomized scoreboard bench for uop_queue: an ordered list of expected uops
// is filled by the stimulus side and drained/compared by a negedge monitor.
module tb_uop_queue;

  localparam int W = 66;

  logic           clk = 1'b0;
  logic           rstn;
  logic           flush;
  logic [1:0]     enq_valid;
  logic [2*W-1:0] enq_uop;
  logic           enq_ready;
  logic [1:0]     deq_valid;
  logic [2*W-1:0] deq_uop;
  logic [1:0]     deq_ready;
  logic [4:0]     count;
  logic           empty;
  logic           full;

  uop_queue dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .enq_valid(enq_valid), .enq_uop(enq_uop), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_uop(deq_uop), .deq_ready(deq_ready),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sb[$];        // expected contents, oldest first
  int           model_count;  // entries visible at the DUT outputs
  int           pending;      // entries accepted this cycle, not yet visible
  bit           mon_en = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_uop();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Monitor: outputs reflect the state committed at the last rising edge.
  always @(negedge clk) begin
    int k;
    if (mon_en) begin
      check("count", W'(count), W'(model_count));
      check("empty", W'(empty), W'(model_count == 0));
      check("full", W'(full), W'(model_count == 16));
      check("enq_ready", W'(enq_ready), W'(model_count <= 14));
      for (int i = 0; i < 2; i++) begin
        check($sformatf("deq_valid[%0d]", i), W'(deq_valid[i]), W'(model_count > i));
        if (model_count > i)
          check($sformatf("deq_uop[%0d]", i), deq_uop[i*W +: W], sb[i]);
      end
    end
    k = 0;
    for (int i = 0; i < 2; i++) begin
      if (k == i && model_count > i && deq_ready[i]) k++;
    end
    if (!rstn || flush) begin
      sb.delete();
      model_count = 0;
    end else begin
      for (int i = 0; i < k; i++) void'(sb.pop_front());
      model_count = model_count - k + pending;
    end
  end

  // Drive one cycle of inputs and record what the queue is expected to accept.
  task automatic step(input logic r, input logic f, input logic [1:0] ev,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] dr);
    rstn      = r;
    flush     = f;
    enq_valid = ev;
    enq_uop   = {b, a};
    deq_ready = dr;
    pending   = 0;
    if (r && !f && model_count <= 14) begin
      if (ev[0]) sb.push_back(a);
      if (ev[1]) sb.push_back(b);
      pending = int'(ev[0]) + int'(ev[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq2(input logic [1:0] ev, input logic [1:0] dr);
    step(1'b1, 1'b0, ev, rnd_uop(), rnd_uop(), dr);
  endtask

  initial begin
    model_count = 0;
    pending     = 0;
    step(1'b0, 1'b1, 2'b11, '0, '0, 2'b11);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 2'b11, '0, '0, 2'b11);

    // Two-lane enqueue after reset, then drain.
    step(1'b1, 1'b0, 2'b11, 66'h2_AAAA_AAAA_AAAA_AAAA, 66'h1_BBBB_BBBB_BBBB_BBBB, 2'b00);
    enq2(2'b00, 2'b11);
    // Single upper-lane enqueue into an empty queue appears on lane 0.
    step(1'b1, 1'b0, 2'b10, 66'h0, 66'h3_CCCC_CCCC_CCCC_CCCC, 2'b00);
    enq2(2'b00, 2'b01);

    // Fill to 15, blocked enqueue, one dequeue reopens, then fill to full.
    for (int i = 0; i < 7; i++) enq2(2'b11, 2'b00);
    enq2(2'b01, 2'b00);
    enq2(2'b11, 2'b00);
    enq2(2'b00, 2'b01);
    enq2(2'b11, 2'b00);
    enq2(2'b11, 2'b00);
    step(1'b1, 1'b1, 2'b00, '0, '0, 2'b00);

    // Gap in deq_ready consumes nothing; balanced enqueue/dequeue keeps count.
    enq2(2'b11, 2'b00);
    enq2(2'b11, 2'b00);
    enq2(2'b00, 2'b10);
    enq2(2'b11, 2'b11);
    enq2(2'b00, 2'b00);
    step(1'b1, 1'b1, 2'b00, '0, '0, 2'b00);

    // Move tail to 15, enqueue across the wrap, then drain in order.
    enq2(2'b01, 2'b00);
    for (int i = 0; i < 7; i++) enq2(2'b11, 2'b11);
    enq2(2'b11, 2'b00);
    for (int i = 0; i < 3; i++) enq2(2'b00, 2'b11);

    // Flush with a simultaneous enqueue retains nothing.
    step(1'b1, 1'b1, 2'b00, '0, '0, 2'b00);
    for (int i = 0; i < 3; i++) enq2(2'b11, 2'b00);
    step(1'b1, 1'b1, 2'b11, rnd_uop(), rnd_uop(), 2'b11);
    enq2(2'b00, 2'b00);

    // Randomized traffic alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      logic r, f;
      logic [1:0] ev, dr;
      r  = ($urandom_range(0, 299) != 0);
      f  = ($urandom_range(0, 59) == 0);
      ev = 2'($urandom());
      dr = 2'($urandom());
      if ((i % 200) < 100 && $urandom_range(0, 2) != 0) dr = 2'b00;
      if ((i % 200) >= 100 && $urandom_range(0, 2) != 0) ev = 2'b00;
      step(r, f, ev, rnd_uop(), rnd_uop(), dr);
    end
    enq2(2'b00, 2'b00);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 SHALL have parameter UOP_WIDTH, default 66, bit width of one packed micro-op.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter ENQ_WIDTH, default 2, enqueue lanes per cycle; 1..DEPTH.
REQ-004 SHALL have parameter DEQ_WIDTH, default 2, dequeue lanes per cycle; 1..DEPTH.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have flush  input  1  discard all entries.
REQ-008 SHALL have enq_valid  input  ENQ_WIDTH  per-lane enqueue request.
REQ-009 SHALL have enq_uop  input  ENQ_WIDTH*UOP_WIDTH  lane i at bits [i*UOP_WIDTH +: UOP_WIDTH].
REQ-010 SHALL have enq_ready  output  1  queue accepts a full enqueue group this cycle.
REQ-011 SHALL have deq_valid  output  DEQ_WIDTH  lane i holds the i-th oldest entry.
REQ-012 SHALL have deq_uop  output  DEQ_WIDTH*UOP_WIDTH  lane packing as enq_uop.
REQ-013 SHALL have deq_ready  input  DEQ_WIDTH  consumer takes lane i.
REQ-014 SHALL have count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have empty  output  1  and full  output  1  status flags.

Function
REQ-016 SHALL store entries in a circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 SHALL drive enq_ready=1 iff (DEPTH - count) >= ENQ_WIDTH, computed from registered count only (no credit from same-cycle dequeue).
REQ-018 SHALL accept the enqueue group iff enq_ready=1 and flush=0; otherwise ignore enq_valid entirely.
REQ-019 SHALL, on accept, write only lanes with enq_valid=1, compacted in ascending lane order to tail, tail+1, ...; tail and count advance by popcount(enq_valid).
REQ-020 SHALL drive deq_valid[i]=1 iff count > i, and deq_uop lane i = entry at (head+i) mod DEPTH; lanes with deq_valid=0 carry don't-care data.
REQ-021 SHALL dequeue in order: number removed k = length of leading run of ones, from lane 0 upward, of (deq_valid & deq_ready); lanes above a gap are not consumed.
REQ-022 SHALL advance head by k and update count = count + popcount(accepted enq) - k in the same cycle.
REQ-023 SHALL have one-cycle latency: an entry written in cycle n appears on deq lanes no earlier than cycle n+1 (no bypass).
REQ-024 SHALL give flush priority over enqueue and dequeue: next cycle head=tail=0, count=0; storage contents need not be cleared.
REQ-025 SHALL drive empty=(count==0), full=(count==DEPTH), combinationally from count.
REQ-026 SHALL treat the payload as opaque; no field decoding.
REQ-027 SHALL never let count exceed DEPTH or underflow below 0 under any input combination.

Reset
REQ-028 SHALL, when rstn=0 at a rising edge, set head=0, tail=0, count=0; reset overrides flush and all handshakes.
REQ-029 SHALL after reset present deq_valid=0, empty=1, full=0, enq_ready=1, count=0.
REQ-030 SHALL, on reset mid-operation, discard all entries with no partial completion of that cycle's enqueue/dequeue.

Verification
REQ-031 SHALL cover: after reset, enq_valid=2'b11 with uops A,B -> next cycle count=2, deq_valid=2'b11, lane0=A, lane1=B.
REQ-032 SHALL cover: enq_valid=2'b10 with uop C on lane1 -> C written at tail, count +1, C appears on deq lane0 when queue was empty.
REQ-033 SHALL cover: fill to count=15 (DEPTH=16) -> enq_ready=0; enq ignored; after one dequeue, count=14 -> enq_ready=1.
REQ-034 SHALL cover: count=4, deq_ready=2'b10 -> nothing consumed; deq_ready=2'b11 with simultaneous 2-lane enqueue -> count stays 4, head advances 2.
REQ-035 SHALL cover: tail at 15, enqueue 2 -> entries at 15 and 0, order preserved at dequeue across wrap.
REQ-036 SHALL cover: count=6, flush=1 with enq_valid=2'b11 -> next cycle count=0, empty=1, deq_valid=0, no entries retained.
